salidas_multi: RTL
==================

# salidas_multi

Parametrised output sequencer for the hash generator's result path. On a `start` pulse it drains a caller-selected number of entries from the result buffer through a registered valid/ready output port. It walks the buffer's read pointer forward or in reverse and signals completion with a one-cycle `fin`. It generalises the fixed 24-bit, 4-entry output stage to arbitrary width, depth and read order, and adds downstream backpressure.

## Interface
- `DATA_W`, 24, width of each buffer entry and of `bounty_out`
- `DEPTH`, 4, number of buffer entries; must be at least 2
- `PTR_W`, 2, read-pointer width; must satisfy 2^PTR_W >= DEPTH
- `REVERSE`, 0, read order: 0 reads entry 0 upward; 1 reads entry n-1 downward to 0

- `clk`  in  1  single clock; all state changes on its rising edge
- `reset_L`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to drain the buffer; sampled only in IDLE
- `num_entradas`  in  PTR_W+1  number of entries to drain, 0..DEPTH; values above DEPTH clamp to DEPTH
- `bounty`  in  DATA_W  buffer read data, asynchronous read at `rd_ptr`
- `ready_in`  in  1  downstream can accept `bounty_out` this cycle
- `rd_ptr`  out  PTR_W  buffer read address
- `bounty_out`  out  DATA_W  registered output word
- `valid_out`  out  1  `bounty_out` holds a word not yet accepted
- `fin`  out  1  one-cycle pulse after the final transfer, or after a start with n=0
- `busy`  out  1  high in every state except IDLE

## Operation
- Internal state: FSM {IDLE, LOAD, SEND, DONE}, latched count `n`, and `remaining` counter (PTR_W+1 bits).
- **IDLE**
  - `valid_out`=0.
  - On `start`, latch n = min(`num_entradas`, DEPTH).
  - If n=0, go to DONE.
  - Otherwise set `rd_ptr` to 0 (REVERSE=0) or n-1 (REVERSE=1), set `remaining`=n, and go to LOAD.
- **LOAD**
  - `bounty_out`<=`bounty`, `valid_out`<=1, `remaining`<=`remaining`-1.
  - Step `rd_ptr` (+1 forward, -1 reverse) if `remaining`>1.
  - Go to SEND.
- **SEND**
  - A transfer occurs on any edge where `valid_out` && `ready_in`.
  - On a transfer with `remaining`>0: `bounty_out`<=`bounty`, `valid_out` stays 1, `remaining` decrements, and `rd_ptr` steps only if the new `remaining` is still >0. The pointer never leaves the range 0..n-1 and never wraps.
  - On a transfer with `remaining`=0: `valid_out`<=0, go to DONE.
  - With `ready_in`=0: `bounty_out`, `valid_out` and `rd_ptr` hold.
- **DONE**
  - `fin`=1 (decoded from state), `rd_ptr`<=0, go to IDLE.
- `start` is ignored while `busy`=1.
- `num_entradas` is only sampled with `start`; later changes have no effect on a drain in progress.
- `bounty` must be stable for the current `rd_ptr` within the same cycle; the block adds no read latency beyond the output register.

## Timing
- Reset values: `rd_ptr`=0, `bounty_out`=0, `valid_out`=0, `fin`=0, `busy`=0, state IDLE.
- `reset_L` low at any time, including mid-drain, forces reset values immediately. The drain is aborted and no `fin` is produced.
- Edge E0 samples `start`=1. `busy` is high from E0.
- `valid_out` with the first word is high after E1.
- With `ready_in` held at 1, the n words transfer on E2..E(n+1), one per cycle with no bubbles.
- `fin` is high for the cycle between E(n+1) and E(n+2). `busy` falls at E(n+2).
- n=0: `fin` is high between E0 and E1, with no `valid_out`.
- Each low cycle of `ready_in` in SEND delays every later event by exactly one cycle.
- A new `start` is accepted on E(n+2) or later.

## Test plan
- Forward drain, DATA_W=24, DEPTH=4, buffer {0xA1,0xB2,0xC3,0xD4}, n=3, `ready_in`=1 -> `bounty_out` 0xA1, 0xB2, 0xC3 on consecutive cycles; `rd_ptr` 0,1,2; `fin` one cycle after the third transfer; `rd_ptr` returns to 0.
- REVERSE=1, same buffer, n=4 -> output order 0xD4, 0xC3, 0xB2, 0xA1; `rd_ptr` 3,2,1,0; no wrap past 0.
- Backpressure: n=2, `ready_in` low for 3 cycles after the first `valid_out` -> 0xA1 held stable with `valid_out`=1 for 3 cycles; then 0xA1, 0xB2 transfer; `fin` 3 cycles later than the unstalled run.
- n=0 and `num_entradas`=7 (clamped to 4) -> `fin` 1 cycle after `start` with no valid words; in the clamped case exactly 4 words transfer.
- `start` pulsed while busy, and `num_entradas` changed mid-drain -> both ignored; the word count equals n latched at the first `start`.
- `reset_L` asserted after the second transfer of a 4-word drain -> all outputs 0 immediately; no `fin`; the next `start` runs a full drain correctly.

Source files
------------

// File: rtl/salidas_multi.sv
// Output sequencer: drains n buffer entries through a registered valid/ready port.
// Read order is forward or reverse; a one-cycle fin marks the end of each drain.
module salidas_multi #(
  parameter int DATA_W  = 24,
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2,
  parameter int REVERSE = 0
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              start,
  input  logic [PTR_W:0]    num_entradas,
  input  logic [DATA_W-1:0] bounty,
  input  logic              ready_in,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic [DATA_W-1:0] bounty_out,
  output logic              valid_out,
  output logic              fin,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_t;

  localparam logic [PTR_W:0]   DEPTH_N = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_N   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W:0]    rem_q, rem_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic [PTR_W:0]    n_clamp;

  function automatic logic [PTR_W-1:0] step(input logic [PTR_W-1:0] p);
    return (REVERSE != 0) ? p - ONE_P : p + ONE_P;
  endfunction

  assign n_clamp = (num_entradas > DEPTH_N) ? DEPTH_N : num_entradas;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    out_d   = out_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          if (n_clamp == '0) begin
            state_d = DONE;
          end else begin
            ptr_d   = (REVERSE != 0) ? n_clamp[PTR_W-1:0] - ONE_P : '0;
            rem_d   = n_clamp;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        out_d   = bounty;
        valid_d = 1'b1;
        rem_d   = rem_q - ONE_N;
        if (rem_q > ONE_N) ptr_d = step(ptr_q);
        state_d = SEND;
      end
      SEND: begin
        if (valid_q && ready_in) begin
          // pointer only advances while a further word remains to fetch
          if (rem_q != '0) begin
            out_d = bounty;
            rem_d = rem_q - ONE_N;
            if (rem_q > ONE_N) ptr_d = step(ptr_q);
          end else begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        ptr_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign rd_ptr     = ptr_q;
  assign bounty_out = out_q;
  assign valid_out  = valid_q;
  assign fin        = (state_q == DONE);
  assign busy       = (state_q != IDLE);

endmodule
